// File: rtl/trace_uart_tx.sv
// Commit-trace serializer: buffers {PC, wr_en, wr_reg, wr_data} records and streams them as UART 8N1 frames.
// Define TRACE_CHECKSUM_EN to append an XOR checksum byte to every record.
module trace_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        trace_valid,
  input  logic [31:0] PC_in,
  input  logic        wr_en,
  input  logic [4:0]  wr_reg,
  input  logic [31:0] wr_data,
  output logic        tx,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int REC_W = 70;
`ifdef TRACE_CHECKSUM_EN
  localparam int NBYTES = 11;
`else
  localparam int NBYTES = 10;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [REC_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             overflow_q;
  logic [7:0]       drop_count_q;

  state_t           state_q, state_d;
  logic [CW-1:0]    clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [3:0]       byte_idx_q, byte_idx_d;

  logic             full, empty, push, drop, pop, bit_end, last_byte;
  logic [REC_W-1:0] head;
  logic [31:0]      head_pc, head_data;
  logic             head_en;
  logic [4:0]       head_reg;
  logic [7:0]       cur_byte;

  assign full  = (count_q == (PW+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  // Full is judged on the registered occupancy, so a same-cycle pop never frees room for a push.
  assign push  = trace_valid & ~full;
  assign drop  = trace_valid & full;

  always_ff @(posedge Clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {PC_in, wr_en, wr_reg, wr_data};
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 8'd1;
      end
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign head_pc   = head[69:38];
  assign head_en   = head[37];
  assign head_reg  = head[36:32];
  assign head_data = head[31:0];

  always_comb begin
    cur_byte = 8'hA5;
    case (byte_idx_q)
      4'd1:    cur_byte = head_pc[31:24];
      4'd2:    cur_byte = head_pc[23:16];
      4'd3:    cur_byte = head_pc[15:8];
      4'd4:    cur_byte = head_pc[7:0];
      4'd5:    cur_byte = {head_en, 2'b00, head_reg};
      4'd6:    cur_byte = head_data[31:24];
      4'd7:    cur_byte = head_data[23:16];
      4'd8:    cur_byte = head_data[15:8];
      4'd9:    cur_byte = head_data[7:0];
`ifdef TRACE_CHECKSUM_EN
      4'd10:   cur_byte = 8'hA5 ^ head_pc[31:24] ^ head_pc[23:16] ^ head_pc[15:8] ^ head_pc[7:0]
                        ^ {head_en, 2'b00, head_reg}
                        ^ head_data[31:24] ^ head_data[23:16] ^ head_data[15:8] ^ head_data[7:0];
`endif
      default: cur_byte = 8'hA5;
    endcase
  end

  assign bit_end   = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
  assign last_byte = (byte_idx_q == 4'(NBYTES - 1));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = bit_end ? '0 : clk_cnt_q + CW'(1);
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    pop        = 1'b0;
    tx         = 1'b1;
    case (state_q)
      IDLE: begin
        clk_cnt_d  = '0;
        bit_idx_d  = 3'd0;
        byte_idx_d = 4'd0;
        if (!empty) state_d = START;
      end
      START: begin
        tx = 1'b0;
        if (bit_end) begin
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        tx = cur_byte[bit_idx_q];
        if (bit_end) begin
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        tx = 1'b1;
        if (bit_end) begin
          if (last_byte) begin
            pop        = 1'b1;
            byte_idx_d = 4'd0;
            // A push landing on this very edge still counts, keeping the stream gap-free.
            state_d    = (count_q > (PW+1)'(1) || push) ? START : IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 4'd1;
            state_d    = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE) | ~empty;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_trace_uart_tx.sv
// Randomized bench for trace_uart_tx: a UART receiver model decodes tx and is compared
// against byte streams built from the record format rules.
module tb_trace_uart_tx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef TRACE_CHECKSUM_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int BYTE_CYC = 10 * CPB;
  localparam int REC_CYC  = NB * BYTE_CYC;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        trace_valid = 1'b0;
  logic [31:0] PC_in = '0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_reg = '0;
  logic [31:0] wr_data = '0;
  logic        tx, busy, overflow;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frame_err = 0;
  logic [7:0] rx_q[$];
  int         rx_start[$];
  logic [7:0] exp_q[$];

  trace_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset), .trace_valid(trace_valid), .PC_in(PC_in),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .tx(tx), .busy(busy), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // UART receiver: samples mid-bit, records start cycle of every byte.
  initial begin
    int s;
    logic [7:0] b;
    logic ok;
    forever begin
      @(negedge Clock);
      if (tx === 1'b0) begin
        s = cyc;
        ok = 1'b1;
        repeat (CPB / 2) @(negedge Clock);
        if (tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge Clock);
          b[i] = tx;
        end
        repeat (CPB) @(negedge Clock);
        if (tx !== 1'b1) ok = 1'b0;
        rx_q.push_back(b);
        rx_start.push_back(s);
        if (!ok) frame_err++;
        repeat (CPB - CPB / 2 - 1) @(negedge Clock);
      end
    end
  end

  function automatic void model_record(input logic [31:0] pc, input logic en,
                                       input logic [4:0] rg, input logic [31:0] d);
    logic [7:0] b [11];
    logic [7:0] x;
    b[0] = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      b[1 + i] = 8'((pc >> (24 - 8 * i)) & 32'hFF);
      b[6 + i] = 8'((d  >> (24 - 8 * i)) & 32'hFF);
    end
    b[5] = 8'(en) * 8'd128 + 8'(rg);
    x = 8'h00;
    for (int i = 0; i < 10; i++) x = x ^ b[i];
    b[10] = x;
    for (int i = 0; i < NB; i++) exp_q.push_back(b[i]);
  endfunction

  task automatic send(input logic [31:0] pc, input logic en, input logic [4:0] rg, input logic [31:0] d);
    trace_valid = 1'b1;
    PC_in = pc; wr_en = en; wr_reg = rg; wr_data = d;
    @(negedge Clock);
  endtask

  task automatic wait_idle(input int bound, output int done);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < bound) begin
      @(negedge Clock);
      n++;
    end
    done = cyc;
    checks++;
    if (n >= bound) begin
      errors++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles, required 0", busy, bound);
    end
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_start.delete();
    exp_q.delete();
    frame_err = 0;
  endtask

  task automatic test_reset();
    #2 Reset = 1'b0;
    #1;
    checks++; if (tx !== 1'b1)        begin errors++; $display("FAIL reset_tx: got %0b required 1", tx); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
    checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow: got %0b required 0", overflow); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d required 0", drop_count); end
    @(negedge Clock);
    trace_valid = 1'b1; PC_in = 32'h1234_5678;
    repeat (3) @(negedge Clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_ignore_valid: busy %0b required 0", busy); end
    trace_valid = 1'b0;
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    checks++; if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++; $display("FAIL post_reset_idle: busy %0b tx %0b required 0/1", busy, tx);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    int e, done, gaps;
    clear_rx();
    e = cyc + 1;
    send(32'h0040_0004, 1'b1, 5'd8, 32'h0000_002A);
    trace_valid = 1'b0;
    model_record(32'h0040_0004, 1'b1, 5'd8, 32'h0000_002A);
    wait_idle(REC_CYC + 500, done);
    checks++; if (done !== e + 1 + REC_CYC) begin errors++; $display("FAIL single_duration: idle at %0d required %0d", done, e + 1 + REC_CYC); end
    checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL single_count: got %0d bytes required %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_byte%0d: got %02h required %02h", i, rx_q[i], exp_q[i]); end
    end
    gaps = frame_err;
    for (int i = 0; i < rx_start.size(); i++) if (rx_start[i] !== e + 1 + i * BYTE_CYC) gaps++;
    checks++; if (gaps != 0) begin errors++; $display("FAIL single_timing: %0d misplaced/bad bytes, required 0", gaps); end
    checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin
      errors++; $display("FAIL single_no_drop: overflow %0b drop %0d required 0/0", overflow, drop_count);
    end
    $display("test_single: %0d bytes received, idle at cycle %0d", rx_q.size(), done);
  endtask

  int burst_first;

  task automatic test_back_to_back();
    logic [31:0] pc, d;
    logic en;
    logic [4:0] rg;
    clear_rx();
    burst_first = cyc + 1;
    for (int i = 0; i < 6; i++) begin
      pc = $urandom; d = $urandom; en = 1'($urandom); rg = 5'($urandom);
      if (i < DEPTH) model_record(pc, en, rg, d);
      send(pc, en, rg, d);
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL b2b_overflow: got %0b required 1", overflow); end
    checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL b2b_drop: got %0d required 2", drop_count); end
    $display("test_back_to_back: overflow %0b drop_count %0d", overflow, drop_count);
  endtask

  task automatic test_saturate();
    int done, gaps;
    for (int i = 0; i < 300; i++) send($urandom, 1'($urandom), 5'($urandom), $urandom);
    trace_valid = 1'b0;
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL sat_drop: got %0d required 255", drop_count); end
    checks++; if (overflow !== 1'b1)     begin errors++; $display("FAIL sat_overflow: got %0b required 1", overflow); end
    wait_idle(DEPTH * REC_CYC + 500, done);
    checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL sat_count: got %0d bytes required %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL sat_byte%0d: got %02h required %02h", i, rx_q[i], exp_q[i]); end
    end
    gaps = frame_err;
    for (int i = 0; i < rx_start.size(); i++) if (rx_start[i] !== burst_first + 1 + i * BYTE_CYC) gaps++;
    checks++; if (gaps != 0) begin errors++; $display("FAIL sat_timing: %0d misplaced/bad bytes, required 0", gaps); end
    checks++; if (drop_count !== 8'd255 || overflow !== 1'b1) begin
      errors++; $display("FAIL sat_sticky: drop %0d overflow %0b required 255/1", drop_count, overflow);
    end
    $display("test_saturate: drop_count %0d, %0d bytes received", drop_count, rx_q.size());
  endtask

  task automatic test_reset_mid();
    int bad;
    send($urandom, 1'($urandom), 5'($urandom), $urandom);
    trace_valid = 1'b0;
    repeat (200) @(negedge Clock);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %0b required 1", busy); end
    #3 Reset = 1'b0;
    #1;
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL mid_reset_tx: got %0b required 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %0b required 0", busy); end
    checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin
      errors++; $display("FAIL mid_reset_flags: overflow %0b drop %0d required 0/0", overflow, drop_count);
    end
    @(negedge Clock);
    Reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clock);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_reset_idle: %0d active cycles after release, required 0", bad); end
    clear_rx();
    $display("test_reset_mid: idle after release");
  endtask

  task automatic test_same_cycle_drop();
    int first, done, gaps;
    logic [31:0] pc, d;
    logic en;
    logic [4:0] rg;
    clear_rx();
    first = cyc + 1;
    for (int i = 0; i < DEPTH; i++) begin
      pc = $urandom; d = $urandom; en = 1'($urandom); rg = 5'($urandom);
      model_record(pc, en, rg, d);
      send(pc, en, rg, d);
    end
    trace_valid = 1'b0;
    while (cyc < first + REC_CYC) @(negedge Clock);
    send($urandom, 1'($urandom), 5'($urandom), $urandom);
    pc = $urandom; d = $urandom; en = 1'($urandom); rg = 5'($urandom);
    model_record(pc, en, rg, d);
    send(pc, en, rg, d);
    trace_valid = 1'b0;
    checks++; if (drop_count !== 8'd1 || overflow !== 1'b1) begin
      errors++; $display("FAIL edge_drop: drop %0d overflow %0b required 1/1", drop_count, overflow);
    end
    wait_idle((DEPTH + 1) * REC_CYC + 500, done);
    checks++; if (done !== first + 1 + (DEPTH + 1) * REC_CYC) begin
      errors++; $display("FAIL edge_duration: idle at %0d required %0d", done, first + 1 + (DEPTH + 1) * REC_CYC);
    end
    checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL edge_count: got %0d bytes required %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL edge_byte%0d: got %02h required %02h", i, rx_q[i], exp_q[i]); end
    end
    gaps = frame_err;
    for (int i = 0; i < rx_start.size(); i++) if (rx_start[i] !== first + 1 + i * BYTE_CYC) gaps++;
    checks++; if (gaps != 0) begin errors++; $display("FAIL edge_timing: %0d misplaced/bad bytes, required 0", gaps); end
    $display("test_same_cycle_drop: drop_count %0d, %0d bytes received", drop_count, rx_q.size());
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    test_same_cycle_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
